// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle registered subtractor.
//   data_out = (data_a - data_b - borrow_in) mod 2^DATA_WIDTH, computed
//   CHUNK_WIDTH bits per clock, least-significant chunk first.
// Optional feature macro: CHUNKED_SUBTRACTOR_OVF_EN adds ovf_out, the
//   two's-complement signed overflow flag of the result.
// FSM state is held in state_q (IDLE/RUN/DONE) for checker binding.
//
// Handshake: start_in is a request sampled only while the block is idle.
//   The edge that sees start_in=1 in IDLE accepts the request and latches
//   data_a, data_b and borrow_in. busy_out is high for the NUM_CHUNKS cycles
//   the operation is in flight. done_out then pulses for exactly one cycle,
//   with data_out/borrow_out already valid. start_in is ignored while busy
//   or done. The results hold until the next completion or reset.
module chunked_subtractor #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic                  borrow_in,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  borrow_out,
  output logic [DATA_WIDTH-1:0] data_out
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
  ,
  output logic                  ovf_out
`endif
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q,      state_d;
  logic [CNT_W-1:0]        cnt_q,        cnt_d;
  logic [DATA_WIDTH-1:0]   a_q,          a_d;
  logic [DATA_WIDTH-1:0]   b_q,          b_d;
  logic                    borrow_q,     borrow_d;
  logic [DATA_WIDTH-1:0]   res_q,        res_d;
  logic [DATA_WIDTH-1:0]   data_out_q,   data_out_d;
  logic                    borrow_out_q, borrow_out_d;
  logic                    busy_q,       busy_d;
  logic                    done_q,       done_d;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
  logic                    a_msb_q,      a_msb_d;
  logic                    b_msb_q,      b_msb_d;
  logic                    ovf_q,        ovf_d;
`endif

  // One chunk of the subtraction; the extra top bit is the borrow out of
  // the chunk (set exactly when the chunk difference went negative).
  logic [CHUNK_WIDTH:0]    chunk_diff;

  // Chunk datapath: current low chunks of the operand shift registers.
  always_comb begin
    chunk_diff = {1'b0, a_q[CHUNK_WIDTH-1:0]}
               - {1'b0, b_q[CHUNK_WIDTH-1:0]}
               - {{CHUNK_WIDTH{1'b0}}, borrow_q};
  end

  // Next-state logic for the FSM, operand/result shifters and outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    borrow_d     = borrow_q;
    res_d        = res_q;
    data_out_d   = data_out_q;
    borrow_out_d = borrow_out_q;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    ovf_d        = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          a_d      = data_a;
          b_d      = data_b;
          borrow_d = borrow_in;
          cnt_d    = '0;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
          a_msb_d  = data_a[DATA_WIDTH-1];
          b_msb_d  = data_b[DATA_WIDTH-1];
`endif
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        // The result register fills from the MSB end so that after the last
        // chunk the first (least-significant) chunk sits at bit 0.
        res_d    = {chunk_diff[CHUNK_WIDTH-1:0], res_q[DATA_WIDTH-1:CHUNK_WIDTH]};
        borrow_d = chunk_diff[CHUNK_WIDTH];
        a_d      = a_q >> CHUNK_WIDTH;
        b_d      = b_q >> CHUNK_WIDTH;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Publish the whole result at once; outputs never show a partial sum.
          data_out_d   = res_d;
          borrow_out_d = chunk_diff[CHUNK_WIDTH];
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
          ovf_d        = (a_msb_q != b_msb_q) && (res_d[DATA_WIDTH-1] != a_msb_q);
`endif
          state_d      = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered versions of the state being entered.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // All state registers; asynchronous active-low reset clears everything.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      res_q        <= '0;
      data_out_q   <= '0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      borrow_q     <= borrow_d;
      res_q        <= res_d;
      data_out_q   <= data_out_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign borrow_out = borrow_out_q;
  assign data_out   = data_out_q;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
  assign ovf_out    = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_subtractor.sv
// tb_chunked_subtractor: directed, table-driven bench for chunked_subtractor
// (default DATA_WIDTH=16, CHUNK_WIDTH=4, so 4 chunks per operation).
module tb_chunked_subtractor;

  logic        clk_in;
  logic        rst_n_in;
  logic        start_in;
  logic        borrow_in;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic        busy_out;
  logic        done_out;
  logic        borrow_out;
  logic [15:0] data_out;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
  logic        ovf_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] prev_d;
  logic        prev_bo;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] exp_d;
    logic        exp_bo;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  chunked_subtractor dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .start_in   (start_in),
    .borrow_in  (borrow_in),
    .data_a     (data_a),
    .data_b     (data_b),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .borrow_out (borrow_out),
    .data_out   (data_out)
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
    ,
    .ovf_out    (ovf_out)
`endif
  );

  // Clock
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One full operation from IDLE, checking latency, busy, done pulse,
  // result hold during RUN and the final result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] exp_d, input logic exp_bo, input logic exp_ovf,
                        input string tag);
    int   cyc;
    int   busy_cnt;
    logic hold_ok;
    data_a    = a;
    data_b    = b;
    borrow_in = bin;
    start_in  = 1'b1;
    tick();
    start_in  = 1'b0;
    // Scramble the inputs: the operation must use only the latched operands.
    data_a    = ~a;
    data_b    = ~b;
    borrow_in = ~bin;
    cyc       = 0;
    busy_cnt  = 0;
    hold_ok   = 1'b1;
    while (done_out !== 1'b1 && cyc < 20) begin
      if (busy_out === 1'b1) busy_cnt++;
      if (data_out !== prev_d || borrow_out !== prev_bo) hold_ok = 1'b0;
      tick();
      cyc++;
    end
    check({tag, " latency"}, cyc, 4);
    check({tag, " busy_cycles"}, busy_cnt, 4);
    check({tag, " result_hold"}, {31'd0, hold_ok}, 1);
    check({tag, " busy_at_done"}, {31'd0, busy_out}, 0);
    check({tag, " data_out"}, {16'd0, data_out}, {16'd0, exp_d});
    check({tag, " borrow_out"}, {31'd0, borrow_out}, {31'd0, exp_bo});
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
    check({tag, " ovf_out"}, {31'd0, ovf_out}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("note: %s has no overflow expectation", tag);
`endif
    prev_d  = exp_d;
    prev_bo = exp_bo;
    tick();
    check({tag, " done_pulse_end"}, {31'd0, done_out}, 0);
    check({tag, " idle_busy"}, {31'd0, busy_out}, 0);
    check({tag, " data_held"}, {16'd0, data_out}, {16'd0, exp_d});
  endtask

  function automatic logic [15:0] pair_a(input int j);
    return 16'h1000 + 16'(j) * 16'h0111;
  endfunction

  function automatic logic [15:0] pair_b(input int j);
    return 16'h0100 + 16'(j) * 16'h0003;
  endfunction

  initial begin
    logic [16:0] full;
    logic        exp_busy;
    logic        exp_done;
    int          k;
    int          done_cnt;

    vecs[0] = '{a: 16'h1234, b: 16'h0034, bin: 1'b0, exp_d: 16'h1200, exp_bo: 1'b0, exp_ovf: 1'b0};
    vecs[1] = '{a: 16'h0000, b: 16'h0001, bin: 1'b0, exp_d: 16'hFFFF, exp_bo: 1'b1, exp_ovf: 1'b0};
    vecs[2] = '{a: 16'h0100, b: 16'h00FF, bin: 1'b1, exp_d: 16'h0000, exp_bo: 1'b0, exp_ovf: 1'b0};
    vecs[3] = '{a: 16'h8000, b: 16'h0001, bin: 1'b0, exp_d: 16'h7FFF, exp_bo: 1'b0, exp_ovf: 1'b1};
    vecs[4] = '{a: 16'h0003, b: 16'h0001, bin: 1'b0, exp_d: 16'h0002, exp_bo: 1'b0, exp_ovf: 1'b0};
    vecs[5] = '{a: 16'hFFFF, b: 16'hFFFF, bin: 1'b1, exp_d: 16'hFFFF, exp_bo: 1'b1, exp_ovf: 1'b0};
    vecs[6] = '{a: 16'h0000, b: 16'h0000, bin: 1'b1, exp_d: 16'hFFFF, exp_bo: 1'b1, exp_ovf: 1'b0};
    vecs[7] = '{a: 16'h7FFF, b: 16'hFFFF, bin: 1'b0, exp_d: 16'h8000, exp_bo: 1'b1, exp_ovf: 1'b1};
    vecs[8] = '{a: 16'hABCD, b: 16'h1234, bin: 1'b0, exp_d: 16'h9999, exp_bo: 1'b0, exp_ovf: 1'b0};
    vecs[9] = '{a: 16'h1234, b: 16'hABCD, bin: 1'b0, exp_d: 16'h6667, exp_bo: 1'b1, exp_ovf: 1'b0};

    // Reset block
    rst_n_in  = 1'b1;
    start_in  = 1'b0;
    borrow_in = 1'b0;
    data_a    = 16'h0;
    data_b    = 16'h0;
    #2;
    rst_n_in  = 1'b0;
    #1;
    check("reset busy", {31'd0, busy_out}, 0);
    check("reset done", {31'd0, done_out}, 0);
    check("reset borrow", {31'd0, borrow_out}, 0);
    check("reset data", {16'd0, data_out}, 0);
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
    check("reset ovf", {31'd0, ovf_out}, 0);
`endif
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();
    prev_d  = 16'h0;
    prev_bo = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_d, vecs[i].exp_bo,
             vecs[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // Back-to-back: start held high, operands changing every cycle. Edges
    // 0, 6 and 12 accept; completions show after edges 4, 10 and 16.
    start_in = 1'b1;
    done_cnt = 0;
    for (int j = 0; j < 18; j++) begin
      data_a    = pair_a(j);
      data_b    = pair_b(j);
      borrow_in = 1'(j & 1);
      tick();
      exp_busy = ((j % 6) < 4);
      exp_done = ((j % 6) == 4);
      check($sformatf("b2b busy e%0d", j), {31'd0, busy_out}, {31'd0, exp_busy});
      check($sformatf("b2b done e%0d", j), {31'd0, done_out}, {31'd0, exp_done});
      if (done_out === 1'b1) done_cnt++;
      if (exp_done) begin
        k    = j - 4;
        full = {1'b0, pair_a(k)} - {1'b0, pair_b(k)} - 17'(k & 1);
        check($sformatf("b2b data op@%0d", k), {16'd0, data_out}, {16'd0, full[15:0]});
        check($sformatf("b2b borrow op@%0d", k), {31'd0, borrow_out}, {31'd0, full[16]});
      end
    end
    start_in = 1'b0;
    check("b2b done count", done_cnt, 3);
    tick();
    tick();

    // Asynchronous reset in the second RUN cycle
    data_a    = 16'hAAAA;
    data_b    = 16'h5555;
    borrow_in = 1'b0;
    start_in  = 1'b1;
    tick();
    start_in  = 1'b0;
    tick();
    check("midrun busy", {31'd0, busy_out}, 1);
    check("midrun data nonzero", {31'd0, (data_out != 16'h0)}, 1);
    rst_n_in = 1'b0;
    #2;
    check("async rst busy", {31'd0, busy_out}, 0);
    check("async rst done", {31'd0, done_out}, 0);
    check("async rst borrow", {31'd0, borrow_out}, 0);
    check("async rst data", {16'd0, data_out}, 0);
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
    check("async rst ovf", {31'd0, ovf_out}, 0);
`endif
    #2;
    rst_n_in = 1'b1;
    tick();
    check("post rst idle", {31'd0, busy_out}, 0);
    prev_d  = 16'h0;
    prev_bo = 1'b0;
    run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
